lfsr_piece_bag: RTL and testbench
=================================

Name: lfsr_piece_bag

Overview:
Parametrised Galois-LFSR random source with a built-in Tetris "7-bag" piece dealer. It replaces the fixed 8-bit free-running randomizer. The new block adds a runtime seed load, zero-lockup protection, a valid/ready piece handshake, and bounded rejection sampling. It sits between the LFSR and the game FSM's spawn logic, and deals one piece id per handshake.

Parameters:
- LFSR_W, 16: LFSR width in bits; must be 8 or greater.
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1: reset and fallback seed; must be non-zero.
- NUM_PIECES, 7: number of distinct pieces; range 2..15.
- PIECE_W, 3: piece id width; 2^PIECE_W >= NUM_PIECES.
- BAG_MODE, 1: 1 = each piece dealt once per bag; 0 = uniform with replacement.
- MAX_TRIES, 8: consecutive rejected draws allowed before the deterministic fallback.

Ports:
- clk, in, 1: the only clock; everything is on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- seed_load, in, 1: for one cycle, load seed_in into the LFSR.
- seed_in, in, LFSR_W: new seed value.
- piece_ready, in, 1: consumer accepts piece_id this cycle.
- piece_valid, out, 1: piece_id holds a dealt piece.
- piece_id, out, PIECE_W: dealt piece, in range 0..NUM_PIECES-1.
- lfsr_out, out, LFSR_W: current LFSR state, for other random uses.
- bag_left, out, 4: number of pieces still available in the current bag (popcount of avail).

Behaviour:
- Reset (rst_n=0 at an edge):
  - lfsr=SEED, piece_valid=0, piece_id=0, avail=all ones, try_cnt=0, state=FILL.
  - bag_left=NUM_PIECES.
- LFSR step, every cycle that is not reset and not seed_load:
  - lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
  - The LFSR free-runs in every state.
- Seed load:
  - seed_load=1 sets lfsr <= seed_in; if seed_in==0, lfsr <= SEED instead (lock-up guard).
  - It also refills avail to all ones and sets try_cnt=0.
  - It does not retract a piece already valid.
- Priority: rst_n > seed_load > LFSR step.
- Draw candidate: cand = lfsr[PIECE_W-1:0], taken from the pre-step (current) value.
- State FILL:
  - Accept the candidate if cand < NUM_PIECES and (BAG_MODE==0 or avail[cand]).
  - On accept: piece_id<=cand, piece_valid<=1, try_cnt<=0, state<=HOLD. In BAG_MODE, clear avail[cand].
  - On reject: try_cnt++.
  - When try_cnt==MAX_TRIES-1 and the draw rejects, deal the lowest-index available piece instead. Worst-case latency is therefore MAX_TRIES cycles.
  - Minimum latency: piece_valid rises 1 cycle after entering FILL.
- Bag refill: if clearing a bit would leave avail all zero, avail <= all ones in the same edge. bag_left never reads 0 after an edge.
- State HOLD:
  - piece_valid=1; piece_id is stable until handshake.
  - On piece_valid&&piece_ready: piece_valid<=0, state<=FILL.
  - Throughput: at most 1 piece per 2 cycles.
- Simultaneous seed_load and handshake: both take effect. The piece is consumed and avail is refilled to all ones; the refill wins over any clear.
- Simultaneous seed_load and accept in FILL: the accept uses the old lfsr value; the refill wins, so avail ends all ones.
- Reset mid-HOLD: the piece is dropped, piece_valid=0 next cycle, no handshake is required.
- BAG_MODE=0: avail is ignored and held all ones; bag_left always equals NUM_PIECES.
- The only combinational outputs are lfsr_out and bag_left, and they are derived from registers.

Decomposition:
- Package tetris_rand_pkg:
  - piece enum: I=0, O=1, T=2, S=3, Z=4, J=5, L=6.
  - DEFAULT_TAPS_16 and DEFAULT_SEED_16 constants.
  - deal state typedef {FILL, HOLD}.
- Sub-module lfsr_galois (params W, TAPS, SEED; ports clk, rst_n, load, load_val, q) holds the zero guard and step logic.
- lfsr_piece_bag instantiates lfsr_galois and contains the avail/try_cnt/handshake FSM plus a priority encoder for the fallback.

Test Plan:
1. Reset then release, piece_ready=0:
   - Cycle 1: lfsr=16'hACE1, cand=1, accepted.
   - Cycle 2: piece_valid=1, piece_id=1, lfsr=16'hE270, bag_left=6.
   - piece_id stays 1 for 20 cycles.
2. piece_ready tied 1, BAG_MODE=1, 70 pieces:
   - Every aligned group of 7 is a permutation of 0..6.
   - bag_left cycles 6..1 then reads 7 after each 7th deal; never 0.
3. seed_load=1 with seed_in=0:
   - Next cycle lfsr=16'hACE1 and bag_left=7.
   - Repeat with seed_in=16'h1234: the dealt sequence is identical on two runs.
4. Force the rejection path:
   - NUM_PIECES=7, seed chosen so the low 3 bits read 7 for MAX_TRIES cycles, or 6 with avail[6]=0.
   - Required: piece_valid within MAX_TRIES cycles, piece_id = lowest set avail bit.
5. seed_load together with the handshake in HOLD:
   - piece_valid=0 next cycle, bag_left=7, lfsr=seed_in.
6. rst_n=0 for one cycle while in HOLD with piece_id=4:
   - Next cycle piece_valid=0, lfsr=16'hACE1, bag_left=7.
   - The sequence then matches scenario 1.

Source files
------------

// File: rtl/tetris_rand_pkg.sv
// Shared types and default constants for the LFSR-driven piece dealer.
package tetris_rand_pkg;

  typedef enum logic [2:0] {
    PieceI = 3'd0,
    PieceO = 3'd1,
    PieceT = 3'd2,
    PieceS = 3'd3,
    PieceZ = 3'd4,
    PieceJ = 3'd5,
    PieceL = 3'd6
  } piece_e;

  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] DEFAULT_TAPS_16 = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED_16 = 16'hACE1;

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } deal_state_e;

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with runtime load; a zero load falls back to SEED.
module lfsr_galois
  import tetris_rand_pkg::*;
#(
  parameter int unsigned   W    = 16,
  parameter logic [W-1:0]  TAPS = W'(DEFAULT_TAPS_16),
  parameter logic [W-1:0]  SEED = W'(DEFAULT_SEED_16)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    if (load) begin
      // An all-zero state would lock the register up forever.
      q_d = (load_val == '0) ? SEED : load_val;
    end else begin
      q_d = (q_q >> 1) ^ (q_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_piece_bag.sv
// 7-bag piece dealer: rejection-samples LFSR bits with a bounded-retry fallback and
// hands out one piece id per valid/ready handshake.
module lfsr_piece_bag
  import tetris_rand_pkg::*;
#(
  parameter int unsigned        LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]  TAPS       = LFSR_W'(DEFAULT_TAPS_16),
  parameter logic [LFSR_W-1:0]  SEED       = LFSR_W'(DEFAULT_SEED_16),
  parameter int unsigned        NUM_PIECES = 7,
  parameter int unsigned        PIECE_W    = 3,
  parameter bit                 BAG_MODE   = 1'b1,
  parameter int unsigned        MAX_TRIES  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_in,
  input  logic               piece_ready,
  output logic               piece_valid,
  output logic [PIECE_W-1:0] piece_id,
  output logic [LFSR_W-1:0]  lfsr_out,
  output logic [3:0]         bag_left
);

  localparam int unsigned     AvailExtW = 2 ** PIECE_W;
  localparam int unsigned     CandW     = PIECE_W + 1;
  localparam int unsigned     TryW      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TryW-1:0] TryLast   = TryW'(MAX_TRIES - 1);
  localparam logic [CandW-1:0] NumLim   = CandW'(NUM_PIECES);

  logic [LFSR_W-1:0]     lfsr;
  deal_state_e           state_q, state_d;
  logic                  valid_q, valid_d;
  logic [PIECE_W-1:0]    id_q, id_d;
  logic [TryW-1:0]       try_q, try_d;
  logic [NUM_PIECES-1:0] avail_q, avail_d, avail_left;
  logic [AvailExtW-1:0]  avail_ext;
  logic [PIECE_W-1:0]    cand, low_idx, deal_id;
  logic                  cand_ok, deal;

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (lfsr)
  );

  // Candidate comes from the pre-step value, so a same-cycle seed load does not affect it.
  assign cand      = lfsr[PIECE_W-1:0];
  assign avail_ext = AvailExtW'(avail_q);
  assign cand_ok   = ({1'b0, cand} < NumLim) && (!BAG_MODE || avail_ext[cand]);

  // Lowest-index available piece, used once the retry budget runs out.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = 0; i < NUM_PIECES; i++) begin
      if (avail_q[NUM_PIECES-1-i]) low_idx = PIECE_W'(NUM_PIECES - 1 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFill;
      valid_q <= 1'b0;
      id_q    <= '0;
      try_q   <= '0;
      avail_q <= '1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      try_q   <= try_d;
      avail_q <= avail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    id_d       = id_q;
    try_d      = try_q;
    avail_d    = avail_q;
    deal       = 1'b0;
    deal_id    = cand;
    avail_left = avail_q;
    case (state_q)
      StFill: begin
        if (cand_ok) begin
          deal = 1'b1;
        end else if (try_q == TryLast) begin
          deal    = 1'b1;
          deal_id = low_idx;
        end else begin
          try_d = try_q + TryW'(1);
        end
        if (deal) begin
          state_d = StHold;
          valid_d = 1'b1;
          id_d    = deal_id;
          try_d   = '0;
          if (BAG_MODE) begin
            for (int unsigned i = 0; i < NUM_PIECES; i++) begin
              if (deal_id == PIECE_W'(i)) avail_left[i] = 1'b0;
            end
            // Refill in the same edge so the bag never reads empty.
            avail_d = (avail_left == '0) ? '1 : avail_left;
          end
        end
      end
      StHold: begin
        if (piece_ready) begin
          valid_d = 1'b0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
    // Seed load restarts the bag; it never retracts a piece already on offer.
    if (seed_load) begin
      avail_d = '1;
      try_d   = '0;
    end
  end

  always_comb begin
    piece_valid = valid_q;
    piece_id    = id_q;
    lfsr_out    = lfsr;
    bag_left    = '0;
    for (int unsigned i = 0; i < NUM_PIECES; i++) begin
      bag_left = bag_left + 4'(avail_q[i]);
    end
  end

endmodule

// File: tb/tb_lfsr_piece_bag.sv
// Bench for lfsr_piece_bag: directed scenarios plus random traffic against a bag-of-pieces model.
module tb_lfsr_piece_bag;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam int          NP   = 7;
  localparam int          MAXT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0;
  logic        piece_ready = 1'b0;
  logic        piece_valid;
  logic [2:0]  piece_id;
  logic [15:0] lfsr_out;
  logic [3:0]  bag_left;

  int checks = 0;
  int errors = 0;

  // Reference model: LFSR value, offered piece, retry count and the pieces left in the bag.
  logic [15:0] m_lfsr;
  bit          m_valid;
  int          m_id;
  int          m_tries;
  int          m_bag[$];

  always #5 clk = ~clk;

  lfsr_piece_bag #(
    .LFSR_W     (16),
    .TAPS       (TAPS),
    .SEED       (SEED),
    .NUM_PIECES (NP),
    .PIECE_W    (3),
    .BAG_MODE   (1'b1),
    .MAX_TRIES  (MAXT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .piece_ready (piece_ready),
    .piece_valid (piece_valid),
    .piece_id    (piece_id),
    .lfsr_out    (lfsr_out),
    .bag_left    (bag_left)
  );

  function automatic void bag_refill();
    m_bag.delete();
    for (int i = 0; i < NP; i++) m_bag.push_back(i);
  endfunction

  function automatic bit bag_has(input int p);
    foreach (m_bag[i]) if (m_bag[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int bag_lowest();
    int lo = NP;
    foreach (m_bag[i]) if (m_bag[i] < lo) lo = m_bag[i];
    return lo;
  endfunction

  function automatic void bag_remove(input int p);
    for (int i = 0; i < m_bag.size(); i++) begin
      if (m_bag[i] == p) begin
        m_bag.delete(i);
        return;
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic tick(input logic rn, input logic sl, input logic [15:0] si, input logic rdy);
    int cand;
    int pick;
    bit deal;
    rst_n       = rn;
    seed_load   = sl;
    seed_in     = si;
    piece_ready = rdy;
    if (!rn) begin
      m_lfsr  = SEED;
      m_valid = 1'b0;
      m_id    = 0;
      m_tries = 0;
      bag_refill();
    end else begin
      cand = int'(m_lfsr[2:0]);
      pick = cand;
      deal = 1'b0;
      if (!m_valid) begin
        if (cand < NP && bag_has(cand)) begin
          deal = 1'b1;
        end else if (m_tries == MAXT - 1) begin
          deal = 1'b1;
          pick = bag_lowest();
        end else begin
          m_tries++;
        end
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (deal) begin
        m_valid = 1'b1;
        m_id    = pick;
        m_tries = 0;
        bag_remove(pick);
        if (m_bag.size() == 0) bag_refill();
      end
      if (sl) begin
        bag_refill();
        m_tries = 0;
      end
      m_lfsr = sl ? ((si == 16'h0) ? SEED : si) : ((m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 16'h0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (piece_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b expected 0", piece_valid);
    end
    checks++;
    if (piece_id !== 3'd0) begin
      errors++; $display("FAIL reset_id: got %0d expected 0", piece_id);
    end
    checks++;
    if (lfsr_out !== 16'hACE1) begin
      errors++; $display("FAIL reset_lfsr: got %h expected ace1", lfsr_out);
    end
    checks++;
    if (bag_left !== 4'd7) begin
      errors++; $display("FAIL reset_bag_left: got %0d expected 7", bag_left);
    end
  endtask

  task automatic test_first_piece();
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (piece_valid !== 1'b1 || piece_id !== 3'd1) begin
      errors++; $display("FAIL first_piece: got valid=%0b id=%0d expected valid=1 id=1",
                         piece_valid, piece_id);
    end
    checks++;
    if (lfsr_out !== 16'hE270) begin
      errors++; $display("FAIL first_lfsr: got %h expected e270", lfsr_out);
    end
    checks++;
    if (bag_left !== 4'd6) begin
      errors++; $display("FAIL first_bag_left: got %0d expected 6", bag_left);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      checks++;
      if (piece_valid !== 1'b1 || piece_id !== 3'd1) begin
        errors++; $display("FAIL hold_stable[%0d]: got valid=%0b id=%0d expected valid=1 id=1",
                           i, piece_valid, piece_id);
      end
      checks++;
      if (lfsr_out !== m_lfsr) begin
        errors++; $display("FAIL hold_lfsr[%0d]: got %h expected %h", i, lfsr_out, m_lfsr);
      end
    end
  endtask

  task automatic test_bag_permutation();
    int dealt = 0;
    int k;
    logic [6:0] seen = '0;
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    for (int cyc = 0; cyc < 2000 && dealt < 70; cyc++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      checks++;
      if (bag_left === 4'd0) begin
        errors++; $display("FAIL bag_never_empty: got 0 expected nonzero");
      end
      if (piece_valid === 1'b1) begin
        dealt++;
        k = dealt % 7;
        checks++;
        if (piece_id !== 3'(m_id)) begin
          errors++; $display("FAIL perm_id[%0d]: got %0d expected %0d", dealt, piece_id, m_id);
        end
        if (piece_id < 3'd7) seen[piece_id] = 1'b1;
        checks++;
        if (bag_left !== ((k == 0) ? 4'd7 : 4'(7 - k))) begin
          errors++; $display("FAIL perm_bag_left[%0d]: got %0d expected %0d", dealt, bag_left,
                             (k == 0) ? 7 : 7 - k);
        end
        if (k == 0) begin
          checks++;
          if (seen !== 7'h7F) begin
            errors++; $display("FAIL perm_group[%0d]: got mask %h expected 7f", dealt / 7, seen);
          end
          seen = '0;
        end
      end
    end
    checks++;
    if (dealt < 70) begin
      errors++; $display("FAIL perm_timeout: got %0d pieces expected 70", dealt);
    end
  endtask

  task automatic test_seed_load();
    int ids[2][14];
    int cnt[2];
    tick(1'b1, 1'b1, 16'h0000, 1'b0);
    checks++;
    if (lfsr_out !== 16'hACE1 || bag_left !== 4'd7) begin
      errors++; $display("FAIL seed_zero: got lfsr=%h bag=%0d expected lfsr=ace1 bag=7",
                         lfsr_out, bag_left);
    end
    for (int r = 0; r < 2; r++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      tick(1'b1, 1'b1, 16'h1234, 1'b1);
      cnt[r] = 0;
      for (int cyc = 0; cyc < 500 && cnt[r] < 14; cyc++) begin
        if (piece_valid === 1'b1) begin
          ids[r][cnt[r]] = int'(piece_id);
          cnt[r]++;
          checks++;
          if (piece_id !== 3'(m_id)) begin
            errors++; $display("FAIL seed_seq_model[%0d]: got %0d expected %0d", r, piece_id,
                               m_id);
          end
        end
        tick(1'b1, 1'b0, 16'h0, 1'b1);
      end
      checks++;
      if (cnt[r] < 14) begin
        errors++; $display("FAIL seed_seq_timeout[%0d]: got %0d pieces expected 14", r, cnt[r]);
      end
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (ids[1][i] !== ids[0][i]) begin
        errors++; $display("FAIL seed_repeat[%0d]: got %0d expected %0d", i, ids[1][i],
                           ids[0][i]);
      end
    end
  endtask

  task automatic test_fallback();
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    // Low ten bits set: the first MAX_TRIES draws all read candidate 7.
    tick(1'b1, 1'b1, 16'h03FF, 1'b1);
    checks++;
    if (piece_valid !== 1'b0 || lfsr_out !== 16'h03FF) begin
      errors++; $display("FAIL fallback_load: got valid=%0b lfsr=%h expected valid=0 lfsr=03ff",
                         piece_valid, lfsr_out);
    end
    for (int i = 0; i < MAXT - 1; i++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      checks++;
      if (piece_valid !== 1'b0) begin
        errors++; $display("FAIL fallback_early[%0d]: got valid=1 expected 0", i);
      end
    end
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (piece_valid !== 1'b1 || piece_id !== 3'd0 || bag_left !== 4'd6) begin
      errors++; $display("FAIL fallback_deal: got valid=%0b id=%0d bag=%0d expected 1 0 6",
                         piece_valid, piece_id, bag_left);
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      checks++;
      if (piece_valid !== m_valid || piece_id !== 3'(m_id) || bag_left !== 4'(m_bag.size())) begin
        errors++; $display("FAIL fallback_after[%0d]: got %0b/%0d/%0d expected %0b/%0d/%0d", i,
                           piece_valid, piece_id, bag_left, m_valid, m_id, m_bag.size());
      end
    end
  endtask

  task automatic test_seed_with_handshake();
    logic [15:0] s;
    s = 16'($urandom_range(1, 65535));
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    tick(1'b1, 1'b1, s, 1'b1);
    checks++;
    if (piece_valid !== 1'b0 || bag_left !== 4'd7 || lfsr_out !== s) begin
      errors++; $display("FAIL seed_handshake: got valid=%0b bag=%0d lfsr=%h expected 0 7 %h",
                         piece_valid, bag_left, lfsr_out, s);
    end
    s = 16'($urandom_range(1, 65535));
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b1, 1'b1, s, 1'b0);
    checks++;
    if (piece_valid !== 1'b1 || piece_id !== 3'd1 || bag_left !== 4'd7 || lfsr_out !== s) begin
      errors++; $display("FAIL seed_accept: got %0b/%0d/%0d/%h expected 1/1/7/%h",
                         piece_valid, piece_id, bag_left, lfsr_out, s);
    end
  endtask

  task automatic test_reset_in_hold();
    bit found = 1'b0;
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
      tick(1'b1, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      if (piece_valid === 1'b1 && piece_id === 3'd4) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_hold_search: got no piece 4 expected one within budget");
    end
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (piece_valid !== 1'b0 || lfsr_out !== 16'hACE1 || bag_left !== 4'd7) begin
      errors++; $display("FAIL reset_hold: got %0b/%h/%0d expected 0/ace1/7",
                         piece_valid, lfsr_out, bag_left);
    end
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (piece_valid !== 1'b1 || piece_id !== 3'd1 || lfsr_out !== 16'hE270) begin
      errors++; $display("FAIL reset_hold_replay: got %0b/%0d/%h expected 1/1/e270",
                         piece_valid, piece_id, lfsr_out);
    end
  endtask

  task automatic test_random();
    logic        rn;
    logic        sl;
    logic [15:0] si;
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 199) != 0);
      sl = ($urandom_range(0, 29) == 0);
      si = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick(rn, sl, si, 1'($urandom_range(0, 1)));
      checks++;
      if (lfsr_out !== m_lfsr || piece_valid !== m_valid || piece_id !== 3'(m_id) ||
          bag_left !== 4'(m_bag.size())) begin
        errors++; $display("FAIL random[%0d]: got %h/%0b/%0d/%0d expected %h/%0b/%0d/%0d", i,
                           lfsr_out, piece_valid, piece_id, bag_left,
                           m_lfsr, m_valid, m_id, m_bag.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_piece();
    test_bag_permutation();
    test_seed_load();
    test_fallback();
    test_seed_with_handshake();
    test_reset_in_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
